// File: rtl/xmacc_capture.sv
// xmacc_capture: samples the accumulator stream once per accumulation period, then rounds,
// shifts and narrows each sample and queues it in a small FIFO for valid/ready draining.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   start                    one-cycle pulse; latches iterations/period/delay/shift
//   iterations, period       number of results, accumulation length (0 acts as 1)
//   delay, shift             cycles before first period, rounding right-shift amount
//   acc_in                   signed 2*DATA_W accumulator value
//   out_data/out_valid/out_ready   FIFO head and handshake
//   busy, done, overflow     run in progress, last-result pulse, sticky drop flag
//
// Build option: define XMACC_CAPTURE_SAT_EN to saturate results to DATA_W instead of wrapping.
module xmacc_capture #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned PERIOD_W = 10,
  parameter int unsigned ITER_W   = 10,
  parameter int unsigned SHIFT_W  = 6,
  parameter int unsigned FIFO_AW  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ITER_W-1:0]     iterations,
  input  logic [PERIOD_W-1:0]   period,
  input  logic [PERIOD_W-1:0]   delay,
  input  logic [SHIFT_W-1:0]    shift,
  input  logic [2*DATA_W-1:0]   acc_in,
  output logic [DATA_W-1:0]     out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow
);

  localparam int unsigned AccW  = 2 * DATA_W;
  localparam int unsigned Depth = 1 << FIFO_AW;

  typedef enum logic [1:0] {StIdle, StDelay, StRun, StFlush} state_e;

  state_e              state_q, state_d;
  logic [ITER_W-1:0]   iter_q, icnt_q, icnt_d;
  logic [PERIOD_W-1:0] plast_q, dlast_q, pcnt_q, pcnt_d, dcnt_q, dcnt_d;
  logic [SHIFT_W-1:0]  shift_q;
  logic                cfg_load, capture;

  // Control FSM
  always_comb begin
    state_d  = state_q;
    pcnt_d   = pcnt_q;
    icnt_d   = icnt_q;
    dcnt_d   = dcnt_q;
    cfg_load = 1'b0;
    capture  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start && iterations != '0) begin
          cfg_load = 1'b1;
          dcnt_d   = '0;
          state_d  = StDelay;
        end
      end
      StDelay: begin
        if (dcnt_q == dlast_q) begin
          state_d = StRun;
          pcnt_d  = '0;
          icnt_d  = '0;
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end
      StRun: begin
        if (pcnt_q == plast_q) begin
          capture = 1'b1;
          pcnt_d  = '0;
          icnt_d  = icnt_q + 1'b1;
          if (icnt_d == iter_q) state_d = StFlush;
        end else begin
          pcnt_d = pcnt_q + 1'b1;
        end
      end
      StFlush: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      pcnt_q  <= '0;
      icnt_q  <= '0;
      dcnt_q  <= '0;
      iter_q  <= '0;
      plast_q <= '0;
      dlast_q <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      pcnt_q  <= pcnt_d;
      icnt_q  <= icnt_d;
      dcnt_q  <= dcnt_d;
      if (cfg_load) begin
        iter_q  <= iterations;
        // Store terminal counts so period==0 and delay==0 both behave as one cycle.
        plast_q <= (period == '0) ? '0 : period - 1'b1;
        dlast_q <= (delay == '0) ? '0 : delay - 1'b1;
        shift_q <= shift;
      end
    end
  end

  assign busy = (state_q != StIdle);
  assign done = (state_q == StFlush);

  // Round half up, arithmetic shift, narrow; one extra bit keeps the rounding add exact.
  logic signed [AccW:0] acc_ext, rnd, t;
  logic [DATA_W-1:0]    res;

  always_comb begin
    acc_ext = {acc_in[AccW-1], acc_in};
    rnd     = '0;
    if (shift_q != '0) rnd = {{AccW{1'b0}}, 1'b1} << (shift_q - 1'b1);
    t = (acc_ext + rnd) >>> shift_q;
`ifdef XMACC_CAPTURE_SAT_EN
    if (t[AccW:DATA_W-1] == '0 || t[AccW:DATA_W-1] == '1) begin
      res = t[DATA_W-1:0];
    end else begin
      res = t[AccW] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    end
`else
    res = DATA_W'(t);
`endif
  end

  // Stage register and FIFO
  logic                 stage_valid_q;
  logic [DATA_W-1:0]    stage_data_q;
  logic [DATA_W-1:0]    mem_q [Depth];
  logic [FIFO_AW-1:0]   wptr_q, rptr_q;
  logic [FIFO_AW:0]     cnt_q;
  logic                 overflow_q, full, fifo_rd, fifo_wr, drop;

  assign out_valid = (cnt_q != '0);
  assign full      = (cnt_q == (FIFO_AW+1)'(Depth));
  assign fifo_rd   = out_valid & out_ready;
  // A read in the same cycle frees the slot, so a write into a full FIFO is still accepted.
  assign fifo_wr   = stage_valid_q & (~full | fifo_rd);
  assign drop      = stage_valid_q & full & ~fifo_rd;
  assign out_data  = out_valid ? mem_q[rptr_q] : '0;
  assign overflow  = overflow_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_valid_q <= 1'b0;
      stage_data_q  <= '0;
      wptr_q        <= '0;
      rptr_q        <= '0;
      cnt_q         <= '0;
      overflow_q    <= 1'b0;
    end else begin
      stage_valid_q <= capture;
      if (capture) stage_data_q <= res;
      if (fifo_wr) wptr_q <= wptr_q + 1'b1;
      if (fifo_rd) rptr_q <= rptr_q + 1'b1;
      case ({fifo_wr, fifo_rd})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
      if (drop) overflow_q <= 1'b1;
      else if (cfg_load) overflow_q <= 1'b0;
    end
  end

  // Storage needs no reset: out_data is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (fifo_wr) mem_q[wptr_q] <= stage_data_q;
  end

endmodule

// File: tb/tb_xmacc_capture.sv
module tb_xmacc_capture;

  logic        clk = 1'b0;
  logic        rst, start, out_ready;
  logic [9:0]  iterations, period, delay;
  logic [5:0]  shift;
  logic [63:0] acc_in;
  logic [31:0] out_data;
  logic        out_valid, busy, done, overflow;

  always #5 clk = ~clk;

  xmacc_capture dut (
    .clk(clk), .rst(rst), .start(start), .iterations(iterations), .period(period),
    .delay(delay), .shift(shift), .acc_in(acc_in), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done),
    .overflow(overflow)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model state. Cycle 0 is the cycle start is driven in.
  int          c;
  logic [63:0] acc_hist [int];
  int          cap_c [$];
  logic [31:0] mq [$];
  logic [31:0] exp_drain [$];
  logic [31:0] got_q [$];
  int          first_valid_c, done_cnt, done_c, busy_low_c;
  bit          start_pend;
  int          acc_mode;
  logic [63:0] acc_const;
  int          cur_shift;

  function automatic logic [31:0] proc(input logic [63:0] a, input int sh);
    logic signed [64:0] t;
    t = $signed({a[63], a});
    if (sh != 0) t = t + (65'sd1 <<< (sh - 1));
    t = t >>> sh;
`ifdef XMACC_CAPTURE_SAT_EN
    if (t > 65'sd2147483647) return 32'h7FFF_FFFF;
    if (t < -65'sd2147483648) return 32'h8000_0000;
`endif
    return t[31:0];
  endfunction

  // One clock cycle: drive inputs, observe outputs, advance the queue model.
  task automatic tick(input bit rdy);
    bit          m_rd, m_wr;
    logic [31:0] m_val;
    c++;
    start = start_pend;
    start_pend = 1'b0;
    out_ready = rdy;
    case (acc_mode)
      0:       acc_in = {$urandom, $urandom};
      1:       acc_in = 64'(c);
      default: acc_in = acc_const;
    endcase
    acc_hist[c] = acc_in;
    if (c >= 1) begin
      if (out_valid && first_valid_c < 0) first_valid_c = c;
      if (done) begin done_cnt++; done_c = c; end
      if (!busy && busy_low_c < 0) busy_low_c = c;
    end
    if (out_valid && rdy) got_q.push_back(out_data);
    m_rd = (mq.size() > 0) && rdy;
    m_wr = 1'b0;
    m_val = '0;
    foreach (cap_c[i]) if (cap_c[i] + 1 == c) begin
      m_wr = 1'b1;
      m_val = proc(acc_hist[cap_c[i]], cur_shift);
    end
    if (m_rd) exp_drain.push_back(mq.pop_front());
    if (m_wr && !(mq.size() == 8 && !m_rd)) mq.push_back(m_val);
    @(posedge clk);
    #1;
  endtask

  task automatic begin_run(input int it, input int per, input int dly, input int sh);
    int m;
    iterations = 10'(it); period = 10'(per); delay = 10'(dly); shift = 6'(sh);
    cur_shift = sh;
    cap_c.delete(); acc_hist.delete(); got_q.delete(); exp_drain.delete();
    m = (dly == 0) ? 1 : dly;
    for (int k = 1; k <= it; k++) cap_c.push_back(m + k * ((per == 0) ? 1 : per));
    first_valid_c = -1; done_cnt = 0; done_c = -1; busy_low_c = -1;
    c = -1;
    start_pend = 1'b1;
  endtask

  // mode 0/1: fixed out_ready, mode 2: random out_ready
  task automatic run_for(input int n, input int mode);
    for (int i = 0; i < n; i++) tick((mode == 2) ? 1'($urandom % 2) : 1'(mode));
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; out_ready = 1'b0; acc_in = '0;
    iterations = '0; period = '0; delay = '0; shift = '0;
    start_pend = 1'b0; acc_mode = 0; c = 0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++; if (out_data !== 32'h0) begin n_err++; $display("FAIL reset_out_data got %h exp 0", out_data); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b exp 0", done); end
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow got %b exp 0", overflow); end
    rst = 1'b0;
  endtask

  task automatic test_basic;
    logic [31:0] exp_v [3] = '{32'd6, 32'd10, 32'd14};
    acc_mode = 1;
    begin_run(3, 4, 2, 0);
    run_for(cap_c[$] + 3, 1);
    run_for(10, 1);
    n_vec++; if (got_q.size() != 3) begin n_err++; $display("FAIL basic_count got %0d exp 3", got_q.size()); end
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (got_q[i] !== exp_v[i]) begin n_err++; $display("FAIL basic_data[%0d] got %h exp %h", i, got_q[i], exp_v[i]); end
    end
    n_vec++; if (first_valid_c != cap_c[0] + 2) begin n_err++; $display("FAIL basic_first_valid got %0d exp %0d", first_valid_c, cap_c[0] + 2); end
    n_vec++; if (done_cnt != 1) begin n_err++; $display("FAIL basic_done_count got %0d exp 1", done_cnt); end
    n_vec++; if (done_c != cap_c[2] + 1) begin n_err++; $display("FAIL basic_done_cycle got %0d exp %0d", done_c, cap_c[2] + 1); end
    n_vec++; if (busy_low_c != cap_c[2] + 2) begin n_err++; $display("FAIL basic_busy_drop got %0d exp %0d", busy_low_c, cap_c[2] + 2); end
  endtask

  task automatic test_const(input string name, input logic [63:0] a, input int sh, input logic [31:0] exp_v);
    acc_mode = 2; acc_const = a;
    begin_run(1, 1, 0, sh);
    run_for(cap_c[$] + 3, 1);
    run_for(6, 1);
    n_vec++;
    if (got_q.size() != 1 || got_q[0] !== exp_v) begin
      n_err++; $display("FAIL %s got %h (n=%0d) exp %h", name, got_q[0], got_q.size(), exp_v);
    end
  endtask

  task automatic test_round_narrow;
    test_const("round_pos", 64'h18, 4, 32'd2);
    test_const("round_neg", -64'sd24, 4, 32'hFFFF_FFFF);
`ifdef XMACC_CAPTURE_SAT_EN
    test_const("narrow_pos", 64'h0000_0001_0000_0000, 0, 32'h7FFF_FFFF);
    test_const("narrow_neg", -(64'sd1 <<< 40), 0, 32'h8000_0000);
`else
    test_const("narrow_pos", 64'h0000_0001_0000_0000, 0, 32'h0000_0000);
    test_const("narrow_neg", -(64'sd1 <<< 40), 0, 32'h0000_0000);
`endif
  endtask

  task automatic test_overflow;
    acc_mode = 0;
    begin_run(10, 1, 0, 0);
    run_for(cap_c[$] + 3, 0);
    n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag got %b exp 1", overflow); end
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL ovf_valid got %b exp 1", out_valid); end
    n_vec++;
    if (out_data !== proc(acc_hist[cap_c[0]], 0)) begin
      n_err++; $display("FAIL ovf_head got %h exp %h", out_data, proc(acc_hist[cap_c[0]], 0));
    end
    run_for(14, 1);
    n_vec++; if (got_q.size() != 8) begin n_err++; $display("FAIL ovf_drain_count got %0d exp 8", got_q.size()); end
    for (int i = 0; i < 8; i++) begin
      n_vec++;
      if (got_q[i] !== proc(acc_hist[cap_c[i]], 0)) begin
        n_err++; $display("FAIL ovf_drain[%0d] got %h exp %h", i, got_q[i], proc(acc_hist[cap_c[i]], 0));
      end
    end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL ovf_empty got %b exp 0", out_valid); end
  endtask

  task automatic test_period0;
    acc_mode = 1;
    begin_run(2, 0, 1, 0);
    run_for(cap_c[$] + 3, 1);
    run_for(6, 1);
    n_vec++; if (got_q.size() != 2) begin n_err++; $display("FAIL p0_count got %0d exp 2", got_q.size()); end
    n_vec++; if (got_q[0] !== 32'd2) begin n_err++; $display("FAIL p0_first got %h exp 2", got_q[0]); end
    n_vec++; if (got_q[1] !== 32'd3) begin n_err++; $display("FAIL p0_second got %h exp 3", got_q[1]); end
  endtask

  task automatic test_ignored_start;
    iterations = '0; start_pend = 1'b1;
    tick(1); tick(1);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL iter0_busy got %b exp 0", busy); end
    acc_mode = 1;
    begin_run(2, 3, 1, 0);
    run_for(3, 1);
    iterations = 10'd7; period = 10'd1; delay = 10'd0; shift = 6'd5; start_pend = 1'b1;
    run_for(cap_c[$], 1);
    run_for(6, 1);
    n_vec++; if (got_q.size() != 2) begin n_err++; $display("FAIL busy_start_count got %0d exp 2", got_q.size()); end
    foreach (exp_drain[i]) begin
      n_vec++;
      if (got_q[i] !== exp_drain[i]) begin n_err++; $display("FAIL busy_start[%0d] got %h exp %h", i, got_q[i], exp_drain[i]); end
    end
  endtask

  task automatic test_random;
    int it;
    for (int r = 0; r < 6; r++) begin
      acc_mode = 0;
      it = 1 + int'($urandom % 6);
      begin_run(it, int'($urandom % 6), int'($urandom % 5), int'($urandom % 64));
      run_for(cap_c[$] + 3, 2);
      run_for(12, 1);
      n_vec++; if (done_cnt != 1) begin n_err++; $display("FAIL rand%0d_done got %0d exp 1", r, done_cnt); end
      n_vec++; if (got_q.size() != it) begin n_err++; $display("FAIL rand%0d_count got %0d exp %0d", r, got_q.size(), it); end
      foreach (exp_drain[i]) begin
        n_vec++;
        if (got_q[i] !== exp_drain[i]) begin n_err++; $display("FAIL rand%0d[%0d] got %h exp %h", r, i, got_q[i], exp_drain[i]); end
      end
    end
  endtask

  task automatic test_midrun_reset;
    acc_mode = 0;
    begin_run(20, 1, 0, 0);
    run_for(14, 0);
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL mrst_pre_busy got %b exp 1", busy); end
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mrst_valid got %b exp 0", out_valid); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL mrst_busy got %b exp 0", busy); end
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL mrst_overflow got %b exp 0", overflow); end
    rst = 1'b0;
    mq.delete(); cap_c.delete();
    begin_run(2, 2, 1, 3);
    run_for(cap_c[$] + 3, 1);
    run_for(6, 1);
    n_vec++; if (got_q.size() != 2) begin n_err++; $display("FAIL mrst_rerun_count got %0d exp 2", got_q.size()); end
    for (int i = 0; i < 2; i++) begin
      n_vec++;
      if (got_q[i] !== proc(acc_hist[cap_c[i]], 3)) begin
        n_err++; $display("FAIL mrst_rerun[%0d] got %h exp %h", i, got_q[i], proc(acc_hist[cap_c[i]], 3));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round_narrow();
    test_overflow();
    test_period0();
    test_ignored_start();
    test_random();
    test_midrun_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/xmacc_capture.md
Name: xmacc_capture

Overview:
- Downstream stage of the multiply-accumulate unit. Consumes the raw 2*DATA_W accumulator stream and samples the completed sum at the end of every accumulation period.
- Each sample is rounded, shifted and optionally saturated to DATA_W, then buffered in a small FIFO.
- Results are drained through a valid/ready interface to the memory write path or host.

Parameters:
- DATA_W, 32, output word width; input is 2*DATA_W.
- PERIOD_W, 10, width of the period and delay fields.
- ITER_W, 10, width of the iterations field.
- SHIFT_W, 6, width of the shift field.
- FIFO_AW, 3, log2 of FIFO depth (8 entries).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; latches the configuration and begins a run.
- iterations  in  ITER_W  number of results to capture.
- period  in  PERIOD_W  accumulation length in cycles; 0 is treated as 1.
- delay  in  PERIOD_W  cycles from start to the first period cycle.
- shift  in  SHIFT_W  right-shift amount applied before narrowing.
- acc_in  in  2*DATA_W  signed accumulator value from the multiply-accumulate unit.
- out_data  out  DATA_W  FIFO head.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  consumer accepts out_data.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse when the last result is written to the FIFO.
- overflow  out  1  sticky flag: a result was dropped because the FIFO was full.

Behaviour:
- Reset values: out_data=0, out_valid=0, busy=0, done=0, overflow=0. FIFO is emptied, all counters are 0, FSM is in IDLE.
- Reset asserted mid-run aborts immediately; no partial state survives.
- FSM states: IDLE, DELAY, RUN, FLUSH.
  - IDLE: on start with iterations!=0, latch iterations, period, delay and shift; clear overflow; go to DELAY.
  - IDLE: start with iterations==0 is ignored.
  - start while busy is ignored.
  - DELAY: count delay cycles. delay==0 passes through in 1 cycle. Then go to RUN with pcnt=0, icnt=0.
  - RUN: pcnt increments each cycle and wraps at period_eff-1, where period_eff=max(period,1).
  - RUN capture cycle: pcnt==period_eff-1. acc_in is sampled, icnt increments. When icnt reaches iterations, go to FLUSH.
  - FLUSH: wait one cycle for the processing stage to write, pulse done, go to IDLE.
- busy=1 in DELAY, RUN and FLUSH.
- Processing stage, 1 register:
  - Compute t = (acc_in + (shift!=0 ? 1<<(shift-1) : 0)) >>> shift in 2*DATA_W+1 bits (round half up, arithmetic shift).
  - Narrow t to DATA_W per the optional feature.
- Latency: capture in cycle T → stage register loads at the end of T → FIFO write at the end of T+1 → out_valid high in cycle T+2, if the FIFO was empty.
- FIFO:
  - Write occurs when the stage holds a valid result.
  - If full, and no read occurs in the same cycle, the result is dropped and overflow is set.
  - Simultaneous read and write when full is accepted.
  - Read on out_valid & out_ready.
  - Pointers wrap modulo depth; count has FIFO_AW+1 bits.
- FIFO contents persist across runs; only rst clears them.
- Output stalls, with out_valid held and out_data stable, while out_ready=0.

Optional Feature:
- Macro XMACC_CAPTURE_SAT_EN.
- Defined: t is clamped to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- Undefined: out = t[DATA_W-1:0] (two's-complement wrap), with no clamp logic synthesised.

Test Plan:
- period=4, delay=2, iterations=3, shift=0, acc_in ramps 1,2,3,… from start+1 → 3 results, equal to acc_in at each capture cycle. First out_valid 2 cycles after first capture; done pulses once; busy drops the cycle after done.
- shift=4, acc_in=0x18 → out 2 (0x18>>4=1.5, rounded up). acc_in=-24 → out -1.
- With XMACC_CAPTURE_SAT_EN, acc_in=0x0000_0001_0000_0000, shift=0 → out 0x7FFF_FFFF. acc_in=-2^40 → 0x8000_0000.
- Without XMACC_CAPTURE_SAT_EN, the same stimulus → out 0x0000_0000.
- out_ready=0, iterations=10, period=1 → 8 results stored, overflow=1, out_data equals first result. Then assert out_ready → exactly 8 results drain in order.
- rst asserted mid-RUN → next cycle: out_valid=0, busy=0, overflow=0. A new start runs normally.
- period=0, iterations=2 → captures on 2 consecutive cycles, as for period=1.
